// File: rtl/cam_capture_if.sv
// Camera-side and frame-buffer-side signal bundle for cam_capture.
// master drives the camera pins and observes the results; slave is the capture block.
interface cam_capture_if;
  logic       ivsync;
  logic       ihref;
  logic [7:0] idata;
  logic       iclr_err;
  logic       ovs_n;
  logic       ode;
  logic [7:0] odata;
  logic [7:0] oframe_cnt;
  logic [1:0] oerr;

  modport master (
    output ivsync, ihref, idata, iclr_err,
    input  ovs_n, ode, odata, oframe_cnt, oerr
  );

  modport slave (
    input  ivsync, ihref, idata, iclr_err,
    output ovs_n, ode, odata, oframe_cnt, oerr
  );
endinterface

// File: rtl/cam_capture.sv
// Y8 camera capture: registers the camera pins, tracks frame/line structure, crops to
// H_RES x V_RES and flags line-length / line-count errors. Two-cycle pin-to-output latency.
module cam_capture #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter logic        VS_POL = 1'b1
) (
  input logic          iclk,
  input logic          irst_n,
  cam_capture_if.slave cam
);

  localparam logic [11:0] HRes = 12'(H_RES);
  localparam logic [10:0] VRes = 11'(V_RES);

  typedef enum logic [1:0] {StWaitVs, StVblank, StActive} state_e;

  // Stage 1 registers
  logic       vs_q, href_q, clr_q, vs_prev_q, href_prev_q;
  logic [7:0] data_q;
  logic       vs_act, vs_rise, vs_fall, href_fall;

  // Control state and stage 2 output registers
  state_e      state_q, state_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d, vcnt_line;
  logic        vs_n_q, vs_n_d, de_q, de_d;
  logic [7:0]  pdata_q, pdata_d, frame_q, frame_d;
  logic [1:0]  err_q, err_d, err_set;

  assign vs_act    = (vs_q == VS_POL);
  assign vs_rise   = vs_act & ~vs_prev_q;
  assign vs_fall   = ~vs_act & vs_prev_q;
  assign href_fall = href_prev_q & ~href_q;

  // Stage 1: capture pins. vsync history resets to "active" so a pulse already in
  // progress at reset release is not mistaken for a fresh rising edge.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      vs_q        <= VS_POL;
      href_q      <= 1'b0;
      data_q      <= '0;
      clr_q       <= 1'b0;
      vs_prev_q   <= 1'b1;
      href_prev_q <= 1'b0;
    end else begin
      vs_q        <= cam.ivsync;
      href_q      <= cam.ihref;
      data_q      <= cam.idata;
      clr_q       <= cam.iclr_err;
      vs_prev_q   <= vs_act;
      href_prev_q <= href_q;
    end
  end

  // Next-state, counters and stage 2 output values
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    frame_d   = frame_q;
    vs_n_d    = 1'b1;
    de_d      = 1'b0;
    pdata_d   = '0;
    err_set   = '0;
    vcnt_line = vcnt_q;
    case (state_q)
      StWaitVs: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (vs_rise) begin
          state_d = StVblank;
          vs_n_d  = 1'b0;
        end
      end
      StVblank: begin
        vs_n_d = ~vs_act;
        hcnt_d = '0;
        vcnt_d = '0;
        if (vs_fall) state_d = StActive;
      end
      StActive: begin
        vs_n_d = ~vs_act;
        // A line that ends in the same cycle as vsync rises is counted first
        if (href_fall) begin
          err_set[0] = (hcnt_q != HRes);
          hcnt_d     = '0;
          vcnt_line  = (vcnt_q == 11'h7FF) ? vcnt_q : vcnt_q + 11'd1;
          vcnt_d     = vcnt_line;
        end
        if (vs_rise) begin
          state_d    = StVblank;
          frame_d    = frame_q + 8'd1;
          err_set[1] = (vcnt_line != VRes);
          // Partial line aborted by vsync is dropped and not counted
          if (href_q && (hcnt_q != 12'd0)) err_set[0] = 1'b1;
          hcnt_d = '0;
          vcnt_d = '0;
        end else if (href_q) begin
          if ((hcnt_q < HRes) && (vcnt_q < VRes)) begin
            de_d    = 1'b1;
            pdata_d = data_q;
          end
          hcnt_d = (hcnt_q == 12'hFFF) ? hcnt_q : hcnt_q + 12'd1;
        end
      end
      default: state_d = StWaitVs;
    endcase
    // Set beats clear when both land in the same cycle
    err_d = (err_q & ~{2{clr_q}}) | err_set;
  end

  // State, counters and registered outputs
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= StWaitVs;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      vs_n_q  <= 1'b1;
      de_q    <= 1'b0;
      pdata_q <= '0;
      frame_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      vs_n_q  <= vs_n_d;
      de_q    <= de_d;
      pdata_q <= pdata_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign cam.ovs_n      = vs_n_q;
  assign cam.ode        = de_q;
  assign cam.odata      = pdata_q;
  assign cam.oframe_cnt = frame_q;
  assign cam.oerr       = err_q;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: a frame/line generator drives two instances (active-high and
// active-low vsync) and derives expected outputs from frame geometry.
module tb_cam_capture;
  localparam int unsigned H = 16;
  localparam int unsigned V = 6;

  logic iclk = 1'b0;
  logic irst_n = 1'b1;
  always #5 iclk = ~iclk;

  cam_capture_if cam0 ();
  cam_capture_if cam1 ();

  cam_capture #(.H_RES(H), .V_RES(V), .VS_POL(1'b1)) dut0 (
    .iclk(iclk), .irst_n(irst_n), .cam(cam0)
  );
  cam_capture #(.H_RES(H), .V_RES(V), .VS_POL(1'b0)) dut1 (
    .iclk(iclk), .irst_n(irst_n), .cam(cam1)
  );

  typedef struct packed {
    logic       de;
    logic [7:0] data;
    logic       vsn;
    logic [1:0] err;
    logic [7:0] frames;
  } exp_t;

  localparam exp_t RstRec = '{de: 1'b0, data: 8'h00, vsn: 1'b1, err: 2'b00, frames: 8'h00};

  int checks = 0;
  int errors = 0;
  int de_cnt = 0;
  bit mon_en = 1'b0;

  // Generator-level model state
  bit         seen_rise, in_frame, prev_vs, clr_req;
  int         lines;
  logic [1:0] exp_err;
  logic [7:0] exp_frames;
  exp_t       pipe0, pipe1;

  // Compare both instances every cycle against the record driven two cycles earlier
  always @(posedge iclk) begin
    #1;
    if (mon_en) begin
      checks += 2;
      if ({cam0.ode, cam0.odata, cam0.ovs_n, cam0.oerr, cam0.oframe_cnt} !== pipe1) begin
        errors++;
        $display("FAIL cycle_dut0 t=%0t got %h want %h", $time,
                 {cam0.ode, cam0.odata, cam0.ovs_n, cam0.oerr, cam0.oframe_cnt}, pipe1);
      end
      if ({cam1.ode, cam1.odata, cam1.ovs_n, cam1.oerr, cam1.oframe_cnt} !== pipe1) begin
        errors++;
        $display("FAIL cycle_dut1 t=%0t got %h want %h", $time,
                 {cam1.ode, cam1.odata, cam1.ovs_n, cam1.oerr, cam1.oframe_cnt}, pipe1);
      end
      if (cam0.ode === 1'b1) de_cnt++;
    end
  end

  // One pixel clock of stimulus with the expected effect of that cycle
  task automatic drive(input bit vs, input bit hr, input logic [7:0] d, input bit de,
                       input logic [1:0] set, input bit inc);
    exp_t r;
    @(negedge iclk);
    if (vs && !prev_vs) seen_rise = 1'b1;
    prev_vs = vs;
    exp_err = (exp_err & ~{clr_req, clr_req}) | set;
    if (inc) exp_frames = exp_frames + 8'd1;
    r.de = de;
    r.data = de ? d : 8'h00;
    r.vsn = seen_rise ? !vs : 1'b1;
    r.err = exp_err;
    r.frames = exp_frames;
    cam0.ivsync = vs;  cam1.ivsync = !vs;
    cam0.ihref = hr;   cam1.ihref = hr;
    cam0.idata = d;    cam1.idata = d;
    cam0.iclr_err = clr_req; cam1.iclr_err = clr_req;
    clr_req = 1'b0;
    pipe1 = pipe0;
    pipe0 = r;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic assert_reset(input bit vs_level);
    mon_en = 1'b0;
    @(negedge iclk);
    #2 irst_n = 1'b0;
    #1;
    seen_rise = 1'b0; in_frame = 1'b0; prev_vs = 1'b1; clr_req = 1'b0;
    lines = 0; exp_err = 2'b00; exp_frames = 8'h00;
    pipe0 = RstRec; pipe1 = RstRec;
    cam0.ivsync = vs_level; cam1.ivsync = !vs_level;
    cam0.ihref = 1'b0; cam1.ihref = 1'b0;
    cam0.idata = 8'h00; cam1.idata = 8'h00;
    cam0.iclr_err = 1'b0; cam1.iclr_err = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge iclk);
    #2 irst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Line of len pixels followed by gap (>=1) blanking cycles
  task automatic line(input int len, input int gap);
    logic [1:0] s;
    logic [7:0] d;
    for (int p = 0; p < len; p++) begin
      d = 8'($urandom);
      drive(1'b0, 1'b1, d, in_frame && (p < H) && (lines < V), 2'b00, 1'b0);
    end
    for (int g = 0; g < gap; g++) begin
      s = 2'b00;
      if (g == 0 && in_frame) begin
        s[0] = (len != H);
        lines++;
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0, s, 1'b0);
    end
  endtask

  // Vsync pulse (ends a running frame) with href noise inside blanking, then porch (>=2)
  task automatic vs_pulse(input int vs_len, input int porch);
    logic [1:0] s;
    bit inc;
    for (int i = 0; i < vs_len; i++) begin
      s = 2'b00;
      inc = 1'b0;
      if (i == 0 && in_frame) begin
        inc = 1'b1;
        s[1] = (lines != V);
      end
      drive(1'b1, (i > 0 && i < vs_len - 1) ? 1'($urandom) : 1'b0, 8'($urandom),
            1'b0, s, inc);
    end
    in_frame = seen_rise;
    lines = 0;
    idle(porch);
  endtask

  task automatic frame(input int nl, input int lo, input int hi, output int exp_de,
                       output bit bad_len);
    int len;
    exp_de = 0;
    bad_len = 1'b0;
    for (int l = 0; l < nl; l++) begin
      len = $urandom_range(hi, lo);
      if (l < V) exp_de += (len < H) ? len : H;
      if (len != H) bad_len = 1'b1;
      line(len, $urandom_range(3, 1));
    end
    vs_pulse($urandom_range(4, 1), $urandom_range(4, 2));
  endtask

  task automatic test_reset();
    assert_reset(1'b1);
    checks += 5;
    if (cam0.ovs_n !== 1'b1) begin errors++; $display("FAIL rst_vs_n got %b want 1", cam0.ovs_n); end
    if (cam0.ode !== 1'b0) begin errors++; $display("FAIL rst_de got %b want 0", cam0.ode); end
    if (cam0.odata !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", cam0.odata); end
    if (cam0.oframe_cnt !== 8'h00) begin
      errors++; $display("FAIL rst_frame got %h want 00", cam0.oframe_cnt);
    end
    if (cam0.oerr !== 2'b00) begin errors++; $display("FAIL rst_err got %b want 00", cam0.oerr); end
    release_reset();
  endtask

  // Released in the middle of a vsync pulse and a frame: nothing forwarded until a full pulse
  task automatic test_release_mid_frame();
    de_cnt = 0;
    repeat (3) drive(1'b1, 1'($urandom), 8'($urandom), 1'b0, 2'b00, 1'b0);
    idle(2);
    repeat (3) line(H, 2);
    checks += 2;
    if (de_cnt !== 0) begin errors++; $display("FAIL pre_sync_de got %0d want 0", de_cnt); end
    if (cam0.oerr !== 2'b00) begin errors++; $display("FAIL pre_sync_err got %b want 00", cam0.oerr); end
    vs_pulse(2, 3);
    checks++;
    if (cam0.oframe_cnt !== 8'h00) begin
      errors++; $display("FAIL first_pulse_frame got %h want 00", cam0.oframe_cnt);
    end
  endtask

  task automatic test_frames();
    int e;
    bit b;
    for (int f = 0; f < 2; f++) begin
      de_cnt = 0;
      frame(V, H, H, e, b);
      checks += 3;
      if (de_cnt !== H * V) begin errors++; $display("FAIL frame_de got %0d want %0d", de_cnt, H * V); end
      if (cam0.oframe_cnt !== 8'(f + 1)) begin
        errors++; $display("FAIL frame_cnt got %0d want %0d", cam0.oframe_cnt, f + 1);
      end
      if (cam0.oerr !== 2'b00) begin errors++; $display("FAIL frame_err got %b want 00", cam0.oerr); end
    end
  endtask

  task automatic test_random_frames();
    int e, nl;
    bit b;
    logic [1:0] want;
    want = 2'b00;
    for (int f = 0; f < 4; f++) begin
      de_cnt = 0;
      nl = $urandom_range(V + 1, V - 1);
      frame(nl, H - 2, H + 2, e, b);
      want = want | {1'(nl != V), b};
      checks += 2;
      if (de_cnt !== e) begin errors++; $display("FAIL rand_de got %0d want %0d", de_cnt, e); end
      if (cam0.oerr !== want) begin errors++; $display("FAIL rand_err got %b want %b", cam0.oerr, want); end
    end
    clr_req = 1'b1;
    idle(3);
  endtask

  task automatic test_long_lines();
    int e;
    bit b;
    de_cnt = 0;
    frame(V, H + 4, H + 4, e, b);
    checks += 2;
    if (de_cnt !== H * V) begin errors++; $display("FAIL long_de got %0d want %0d", de_cnt, H * V); end
    if (cam0.oerr !== 2'b01) begin errors++; $display("FAIL long_err got %b want 01", cam0.oerr); end
    clr_req = 1'b1;
    idle(3);
    checks++;
    if (cam0.oerr !== 2'b00) begin errors++; $display("FAIL clear_err got %b want 00", cam0.oerr); end
  endtask

  task automatic test_extra_lines();
    int e;
    bit b;
    de_cnt = 0;
    frame(V + 2, H, H, e, b);
    checks += 2;
    if (de_cnt !== H * V) begin errors++; $display("FAIL extra_de got %0d want %0d", de_cnt, H * V); end
    if (cam0.oerr !== 2'b10) begin errors++; $display("FAIL extra_err got %b want 10", cam0.oerr); end
    clr_req = 1'b1;
    idle(3);
  endtask

  // Vsync rises at pixel 5 of line 3 while href is high
  task automatic test_abort();
    logic [7:0] f0;
    f0 = exp_frames;
    de_cnt = 0;
    repeat (3) line(H, 2);
    for (int p = 0; p < 5; p++) drive(1'b0, 1'b1, 8'($urandom), 1'b1, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 8'($urandom), 1'b0, 2'b11, 1'b1);
    repeat (2) drive(1'b1, 1'b1, 8'($urandom), 1'b0, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
    in_frame = 1'b1;
    lines = 0;
    idle(3);
    checks += 3;
    if (de_cnt !== 3 * H + 5) begin
      errors++; $display("FAIL abort_de got %0d want %0d", de_cnt, 3 * H + 5);
    end
    if (cam0.oerr !== 2'b11) begin errors++; $display("FAIL abort_err got %b want 11", cam0.oerr); end
    if (cam0.oframe_cnt !== f0 + 8'd1) begin
      errors++; $display("FAIL abort_frame got %h want %h", cam0.oframe_cnt, f0 + 8'd1);
    end
    clr_req = 1'b1;
    idle(3);
  endtask

  // Last line's href fall coincides with the vsync rise: that line still counts
  task automatic test_simultaneous();
    logic [1:0] s;
    for (int k = 0; k < 2; k++) begin
      for (int l = 0; l < V - 1 + k; l++) line(H, 2);
      for (int p = 0; p < H; p++) drive(1'b0, 1'b1, 8'($urandom), lines < V, 2'b00, 1'b0);
      lines++;
      s = {1'(lines != V), 1'b0};
      drive(1'b1, 1'b0, 8'h00, 1'b0, s, 1'b1);
      drive(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
      in_frame = 1'b1;
      lines = 0;
      idle(3);
      checks++;
      if (cam0.oerr !== (k == 0 ? 2'b00 : 2'b10)) begin
        errors++; $display("FAIL simul_err k=%0d got %b want %b", k, cam0.oerr, k == 0 ? 2'b00 : 2'b10);
      end
    end
    clr_req = 1'b1;
    idle(3);
  endtask

  task automatic test_reset_mid_frame();
    int e;
    bit b;
    repeat (2) line(H, 2);
    for (int p = 0; p < 7; p++) drive(1'b0, 1'b1, 8'($urandom), 1'b1, 2'b00, 1'b0);
    assert_reset(1'b0);
    checks += 3;
    if (cam0.ode !== 1'b0) begin errors++; $display("FAIL midrst_de got %b want 0", cam0.ode); end
    if (cam0.oframe_cnt !== 8'h00) begin
      errors++; $display("FAIL midrst_frame got %h want 00", cam0.oframe_cnt);
    end
    if (cam0.odata !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", cam0.odata); end
    cam0.ihref = 1'b1; cam1.ihref = 1'b1;
    release_reset();
    de_cnt = 0;
    line(9, 2);
    repeat (2) line(H, 2);
    vs_pulse(2, 2);
    checks++;
    if (de_cnt !== 0) begin errors++; $display("FAIL midrst_nosync_de got %0d want 0", de_cnt); end
    frame(V, H, H, e, b);
    checks += 2;
    if (de_cnt !== H * V) begin errors++; $display("FAIL midrst_de_cnt got %0d want %0d", de_cnt, H * V); end
    if (cam0.oframe_cnt !== 8'h01) begin
      errors++; $display("FAIL midrst_frame_cnt got %h want 01", cam0.oframe_cnt);
    end
  endtask

  // 256 one-line frames: counter wraps; a clear landing with an error set keeps the set
  task automatic test_wrap();
    logic [7:0] f0;
    f0 = exp_frames;
    for (int i = 0; i < 256; i++) begin
      line(3, 1);
      if (i == 100) clr_req = 1'b1;
      vs_pulse(1, 2);
      if (i == 100) begin
        checks++;
        if (cam0.oerr !== 2'b10) begin errors++; $display("FAIL clr_vs_set got %b want 10", cam0.oerr); end
      end
    end
    checks++;
    if (cam0.oframe_cnt !== f0) begin
      errors++; $display("FAIL wrap_frame got %h want %h", cam0.oframe_cnt, f0);
    end
  endtask

  initial begin
    test_reset();
    test_release_mid_frame();
    test_frames();
    test_random_frames();
    test_long_lines();
    test_extra_lines();
    test_abort();
    test_simultaneous();
    test_reset_mid_frame();
    test_wrap();
    idle(3);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
